uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters sharing one uart_tx (1..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 16, clk cycles allowed for tx_busy to rise after tx_start (2..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic in this domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte pending.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port tx_start  output  1  start request to uart_tx.
REQ-009 SHALL have port tx_data  output  8  byte to uart_tx.
REQ-010 SHALL have port tx_busy  input  1  busy flag from uart_tx.
REQ-011 SHALL have port grant_id  output  clog2(NUM_REQ), min 1  index of the requester whose byte is in flight.
REQ-012 SHALL have port timeout_err  output  1  one-cycle pulse on start timeout.

Function
REQ-013 SHALL implement states IDLE, START, DRAIN.
REQ-014 SHALL, in IDLE with tx_busy low and any req_valid high, assert exactly one req_ready bit combinationally in that cycle; if tx_busy is high, all req_ready bits SHALL stay low.
REQ-015 SHALL select by round-robin: search begins at last granted index + 1 modulo NUM_REQ; after reset, requester 0 has highest priority.
REQ-016 SHALL, on transfer, register the byte into tx_data and the index into grant_id, advance the pointer, and enter START with tx_start high on the next cycle (1-cycle latency).
REQ-017 SHALL hold tx_start high and tx_data stable in START until tx_busy is sampled high, then clear tx_start and enter DRAIN.
REQ-018 SHALL remain in DRAIN until tx_busy is sampled low, then return to IDLE; no grant SHALL occur in START or DRAIN.
REQ-019 SHALL, when all requesters are continuously valid, grant 0,1,...,NUM_REQ-1,0,... with no requester starved.
REQ-020 SHALL require requesters to hold req_valid and req_data stable until accepted; behaviour on early withdrawal is undefined.
REQ-021 SHALL keep tx_data and grant_id unchanged from START entry until the next transfer.

Reset
REQ-022 SHALL, on rst_n low, immediately force state IDLE, tx_start 0, tx_data 0x00, grant_id 0, req_ready 0, timeout_err 0, RR pointer to NUM_REQ-1 (so 0 is searched first), timeout counter 0.
REQ-023 SHALL, on reset mid-byte, drop tx_start at once; the in-flight byte is lost and not re-offered.

Configuration
REQ-024 SHALL, with UART_ARB_START_TIMEOUT_EN defined, count cycles in START; when START_TIMEOUT cycles elapse without tx_busy high, clear tx_start, pulse timeout_err for one cycle, discard the byte, and return to IDLE.
REQ-025 SHALL, without UART_ARB_START_TIMEOUT_EN, wait in START indefinitely, tie timeout_err to 0, and contain no counter logic.

Structure
REQ-026 SHALL take the state enum and the default parameter constants from the shared package uart_arb_pkg.
REQ-027 SHALL place the round-robin pick and pointer register in sub-module rr_arbiter (inputs: request vector, advance; outputs: one-hot grant, index).

Verification
REQ-028 SHALL cover single requester: req 2 valid with 0x41 -> req_ready[2] one cycle; tx_start next cycle; tx_data 0x41; grant_id 2.
REQ-029 SHALL cover contention: all 4 requesters valid with 0x10..0x13 from reset -> uart_tx receives 0x10, 0x11, 0x12, 0x13 in order.
REQ-030 SHALL cover external busy: tx_busy held high in IDLE for 50 cycles with req 0 valid -> no req_ready until tx_busy falls.
REQ-031 SHALL cover timeout (macro on, START_TIMEOUT 16): tx_busy never rises -> tx_start falls after 16 cycles; timeout_err pulses once; next request granted normally.
REQ-032 SHALL cover reset mid-DRAIN: rst_n low -> tx_start 0 and state IDLE immediately; after release, req 0 wins against req 3.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx byte arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEFAULT       = 4;
  localparam int START_TIMEOUT_DEFAULT = 16;
  localparam int TO_CNT_W              = 8;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: search starts one past the last advanced index; pointer resets to N-1.
// Combinational grant, pointer updates on advance_i.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEFAULT,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

  logic [IW-1:0] last_q, last_d;
  logic          found;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int off = 1; off <= N; off++) begin
      j = int'(last_q) + off;
      if (j >= N) j = j - N;
      if (!found && req_i[j[IW-1:0]]) begin
        gnt_o[j[IW-1:0]] = 1'b1;
        idx_o            = j[IW-1:0];
        found            = 1'b1;
      end
    end
  end

  assign last_d = advance_i ? idx_o : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PTR_RST;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_tx among NUM_REQ byte sources; tx_start one cycle after accept.
// req_ready held low while tx_busy is high or a byte is in flight; UART_ARB_START_TIMEOUT_EN adds a start timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEFAULT,
  parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [8*NUM_REQ-1:0]            req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            tx_start,
  output logic [7:0]                      tx_data,
  input  logic                            tx_busy,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            timeout_err
);

  localparam int IW = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IW-1:0]       rr_idx;
  logic                xfer;
  logic [7:0]          sel_byte;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [IW-1:0]       grant_id_q, grant_id_d;
  logic                to_hit;

  // Gated by rst_n so no accept strobe can escape while reset is held.
  assign req_ready = (rst_n && (state_q == IDLE) && !tx_busy) ? rr_gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (xfer),
    .gnt_o     (rr_gnt),
    .idx_o     (rr_idx)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) sel_byte = req_data[8*i +: 8];
    end
  end

`ifdef UART_ARB_START_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(START_TIMEOUT - 1);

  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                to_err_q;

  assign to_hit   = (state_q == START) && !tx_busy && (to_cnt_q == TO_LAST);
  assign to_cnt_d = ((state_q == START) && !tx_busy && !to_hit) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_hit;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = START;
          tx_data_d  = sel_byte;
          grant_id_d = rr_idx;
        end
      end
      START: begin
        if (tx_busy)     state_d = DRAIN;
        else if (to_hit) state_d = IDLE;
      end
      DRAIN: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Decoded from state so reset drops it asynchronously with the state register.
  assign tx_start = (state_q == START);
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of {id, byte} checked as uart_tx picks each byte up.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  int vectors = 0;
  int errs    = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [7:0] b);
    req_valid[id]      = 1'b1;
    req_data[8*id +: 8] = b;
  endtask

  task automatic expect_byte(input int id, input logic [7:0] b);
    sb_q.push_back({3'(id), b});
  endtask

  // Plays uart_tx: waits for tx_start, checks the byte, then runs busy for hold cycles.
  task automatic serve(input int hold);
    int n;
    logic [10:0] e;
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("tx_start_rise", 32'(tx_start), 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 11'h7FF;
    chk("tx_data", 32'(tx_data), 32'(e[7:0]));
    chk("grant_id", 32'(grant_id), 32'(e[10:8]));
    req_valid[e[9:8]] = 1'b0;
    tx_busy = 1'b1;
    tick();
    chk("tx_start_drop", 32'(tx_start), 32'd0);
    repeat (hold) tick();
    chk("tx_data_hold", 32'(tx_data), 32'(e[7:0]));
    tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int pulses;
    logic seen;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tick();
    req_valid = 4'hF;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // single requester
    drive_req(2, 8'h41);
    expect_byte(2, 8'h41);
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("single_ready_once", 32'(req_ready), 32'd0);
    chk("single_start_latency", 32'(tx_start), 32'd1);
    serve(4);

    // contention from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_req(k, 8'h10 + 8'(k));
      expect_byte(k, 8'h10 + 8'(k));
    end
    #1;
    chk("contend_first_ready", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 4; k++) serve(3);
    chk("contend_sb_drained", 32'(sb_q.size()), 32'd0);

    // external busy
    tx_busy = 1'b1;
    drive_req(0, 8'h5A);
    expect_byte(0, 8'h5A);
    seen = 1'b0;
    repeat (50) begin
      tick();
      if (req_ready !== 4'b0000) seen = 1'b1;
    end
    chk("busy_no_ready", 32'(seen), 32'd0);
    tx_busy = 1'b0;
    #1;
    chk("busy_release_ready", 32'(req_ready), 32'b0001);
    serve(2);

`ifdef UART_ARB_START_TIMEOUT_EN
    drive_req(1, 8'h77);
    tick();
    chk("to_start", 32'(tx_start), 32'd1);
    req_valid[1] = 1'b0;
    n = 0;
    pulses = 0;
    while (tx_start === 1'b1 && n < 40) begin
      if (timeout_err === 1'b1) pulses++;
      tick();
      n++;
    end
    repeat (3) begin
      if (timeout_err === 1'b1) pulses++;
      tick();
    end
    chk("to_start_cycles", 32'(n), 32'd16);
    chk("to_err_pulses", 32'(pulses), 32'd1);
    drive_req(2, 8'h99);
    expect_byte(2, 8'h99);
    serve(2);
`else
    drive_req(1, 8'h77);
    expect_byte(1, 8'h77);
    tick();
    seen = 1'b0;
    repeat (40) begin
      if (timeout_err !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("no_to_start_held", 32'(tx_start), 32'd1);
    chk("no_to_err", 32'(seen), 32'd0);
    serve(2);
`endif

    // reset mid-DRAIN
    drive_req(1, 8'h33);
    tick();
    chk("mid_start_data", 32'(tx_data), 32'h33);
    req_valid[1] = 1'b0;
    tx_busy = 1'b1;
    tick();
    chk("mid_drain_start_low", 32'(tx_start), 32'd0);
    drive_req(0, 8'h0A);
    drive_req(3, 8'h3C);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_req0_wins", 32'(req_ready), 32'b0001);
    expect_byte(0, 8'h0A);
    expect_byte(3, 8'h3C);
    serve(2);
    serve(2);
    chk("final_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
